layer2_conv_sched: RTL and testbench

- Sequencer for the layer-2 5x5 convolution PE: runs conv2 as IN_CH x OUT_CH passes over one shared PE.
- Per pass: pulses pe_reset, loads 25 weights, streams a 12x12 input map, collects 64 (8x8) results.
- Accumulates partial sums across input channels in a 64-entry buffer, then emits each output map plus bias.
- Sits between the layer-1 feature buffer / weight ROM and the pooling stage.

---
 rtl/layer2_conv_sched.sv | 173 +++++++++++++++++
 tb/tb_layer2_conv_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer2_conv_sched.sv
// Layer-2 5x5 conv sequencer: runs IN_CH x OUT_CH passes over one shared PE, accumulates, emits map + bias.
// Define LAYER2_SCHED_RELU_EN to clamp emitted samples at zero.
module layer2_conv_sched #(
  parameter int IN_CH     = 6,
  parameter int OUT_CH    = 16,
  parameter int IMG_W     = 12,
  parameter int OUT_W     = 8,
  parameter int DRAIN_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        wt_rd_en,
  output logic [11:0] wt_addr,
  input  logic [15:0] wt_data,
  output logic        fm_rd_en,
  output logic [9:0]  fm_addr,
  input  logic [15:0] fm_data,
  output logic        pe_reset,
  output logic        pe_enable,
  output logic [15:0] pe_datain,
  output logic [15:0] pe_weight,
  output logic        pe_weight_enable,
  input  logic        pe_conv_out,
  input  logic [15:0] pe_dataout,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [3:0]  out_ch,
  output logic [5:0]  out_idx
);
  localparam int NRES = OUT_W * OUT_W;
  localparam int NPIX = IMG_W * IMG_W;
  localparam int NWT  = 25;
  localparam int WPB  = IN_CH * NWT + 1;
  localparam int IW   = $clog2(NRES);

  typedef enum logic [2:0] {
    S_IDLE, S_PRST, S_LOADW, S_STREAM, S_DRAIN, S_NEXT, S_EMIT, S_DONE
  } state_t;

  state_t        r_state, w_next;
  logic [15:0]   r_k;
  logic [7:0]    r_cnt;
  logic [3:0]    r_ic, r_oc;
  logic          r_err, r_wt_vld, r_fm_vld;
  logic [15:0]   r_bias;
  logic [15:0]   r_psum [NRES];

  logic          w_wt_rd, w_fm_rd, w_drain_en, w_timeout, w_cap;
  logic          w_last_ic, w_last_oc, w_cnt_full;
  logic [IW-1:0] w_cidx, w_eidx;
  logic [15:0]   w_bias, w_sum, w_res;

  assign w_last_ic  = (r_ic == 4'(IN_CH - 1));
  assign w_last_oc  = (r_oc == 4'(OUT_CH - 1));
  assign w_cnt_full = (r_cnt >= 8'(NRES));
  assign w_cidx     = r_cnt[IW-1:0];
  assign w_eidx     = r_k[IW-1:0];
  // A clear in PRST outranks any late result arriving that cycle.
  assign w_cap      = pe_conv_out && !w_cnt_full && (r_state != S_PRST);

  always_comb begin
    w_next     = r_state;
    w_wt_rd    = 1'b0;
    w_fm_rd    = 1'b0;
    w_drain_en = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_PRST;
      S_PRST:   w_next = S_LOADW;
      S_LOADW:  if (r_k < 16'(NWT)) w_wt_rd = 1'b1;
                else w_next = S_STREAM;
      S_STREAM: if (r_k < 16'(NPIX)) w_fm_rd = 1'b1;
                else w_next = w_cnt_full ? S_NEXT : S_DRAIN;
      S_DRAIN: begin
        if (w_cnt_full) w_next = S_NEXT;
        else begin
          w_drain_en = 1'b1;
          if (r_k == 16'(DRAIN_MAX - 1)) begin
            w_timeout = 1'b1;
            w_next    = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (!w_last_ic) w_next = S_PRST;
        else begin
          w_wt_rd = 1'b1;
          w_next  = S_EMIT;
        end
      end
      S_EMIT:   if (r_k == 16'(NRES - 1)) w_next = w_last_oc ? S_DONE : S_PRST;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_cnt    <= '0;
      r_ic     <= '0;
      r_oc     <= '0;
      r_err    <= 1'b0;
      r_wt_vld <= 1'b0;
      r_fm_vld <= 1'b0;
      r_bias   <= '0;
    end else begin
      r_state  <= w_next;
      r_k      <= (w_next != r_state || r_state == S_IDLE) ? 16'd0 : r_k + 16'd1;
      r_wt_vld <= w_wt_rd && (r_state == S_LOADW);
      r_fm_vld <= w_fm_rd;
      if (r_state == S_IDLE && start) begin
        r_oc  <= '0;
        r_ic  <= '0;
        r_err <= 1'b0;
      end
      if (r_state == S_NEXT && !w_last_ic) r_ic <= r_ic + 4'd1;
      if (r_state == S_EMIT && w_next == S_PRST) begin
        r_oc <= r_oc + 4'd1;
        r_ic <= '0;
      end
      if (w_timeout) r_err <= 1'b1;
      if (r_state == S_EMIT && r_k == 16'd0) r_bias <= wt_data;
      if (r_state == S_PRST) r_cnt <= '0;
      else if (w_cap) r_cnt <= r_cnt + 8'd1;
    end
  end

  // First input channel overwrites, later channels accumulate.
  always_ff @(posedge clk) begin
    if (!reset && w_cap)
      r_psum[w_cidx] <= ((r_ic == 4'd0) ? 16'd0 : r_psum[w_cidx]) + pe_dataout;
  end

  always_comb begin
    wt_addr = '0;
    fm_addr = '0;
    if (w_wt_rd) begin
      if (r_state == S_NEXT) wt_addr = 12'(int'(r_oc) * WPB + IN_CH * NWT);
      else                   wt_addr = 12'(int'(r_oc) * WPB + int'(r_ic) * NWT + int'(r_k));
    end
    if (w_fm_rd) fm_addr = 10'(int'(r_ic) * NPIX + int'(r_k));
  end

  // Bias arrives on wt_data in the first EMIT cycle and is held afterwards.
  assign w_bias = (r_k == 16'd0) ? wt_data : r_bias;
  assign w_sum  = r_psum[w_eidx] + w_bias;
`ifdef LAYER2_SCHED_RELU_EN
  assign w_res  = w_sum[15] ? 16'd0 : w_sum;
`else
  assign w_res  = w_sum;
`endif

  assign busy             = (r_state != S_IDLE);
  assign done             = (r_state == S_DONE);
  assign err              = r_err;
  assign wt_rd_en         = w_wt_rd;
  assign fm_rd_en         = w_fm_rd;
  assign pe_reset         = (r_state == S_PRST);
  assign pe_enable        = r_fm_vld || w_drain_en;
  assign pe_datain        = r_fm_vld ? fm_data : 16'd0;
  assign pe_weight_enable = r_wt_vld;
  assign pe_weight        = r_wt_vld ? wt_data : 16'd0;
  assign out_valid        = (r_state == S_EMIT);
  assign out_data         = out_valid ? w_res : 16'd0;
  assign out_ch           = out_valid ? r_oc : 4'd0;
  assign out_idx          = out_valid ? r_k[5:0] : 6'd0;
endmodule

// File: tb/tb_layer2_conv_sched.sv
// Bench for layer2_conv_sched: ROM/feature memories, a behavioural 5x5 PE, and a whole-layer expected-output model.
module tb_layer2_conv_sched;
  localparam int IN_CH  = 6;
  localparam int OUT_CH = 16;
`ifdef LAYER2_SCHED_RELU_EN
  localparam int EXP_NEG = 0;
`else
  localparam int EXP_NEG = -50;
`endif

  logic        clk, reset, start;
  logic        busy, done, err, wt_rd_en, fm_rd_en;
  logic [11:0] wt_addr;
  logic [9:0]  fm_addr;
  logic [15:0] wt_data, fm_data, pe_datain, pe_weight, pe_dataout, out_data;
  logic        pe_reset, pe_enable, pe_weight_enable, pe_conv_out, out_valid;
  logic [3:0]  out_ch;
  logic [5:0]  out_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  layer2_conv_sched dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_data(wt_data),
    .fm_rd_en(fm_rd_en), .fm_addr(fm_addr), .fm_data(fm_data),
    .pe_reset(pe_reset), .pe_enable(pe_enable), .pe_datain(pe_datain),
    .pe_weight(pe_weight), .pe_weight_enable(pe_weight_enable),
    .pe_conv_out(pe_conv_out), .pe_dataout(pe_dataout),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_idx(out_idx)
  );

  logic signed [15:0] wrom [4096];
  logic signed [15:0] from [1024];
  always @(posedge clk) begin
    if (wt_rd_en) wt_data <= wrom[wt_addr];
    if (fm_rd_en) fm_data <= from[fm_addr];
  end

  // PE: registered result one cycle after the pixel that completes each 5x5 window.
  logic signed [15:0] pe_w [25];
  logic signed [15:0] pe_img [144];
  int pe_widx, pe_pix, pe_emitted, pe_pass, drop_pass;
  bit inject, pe_extra;
  always @(posedge clk) begin : pe_model
    int r, c, acc;
    pe_conv_out <= 1'b0;
    if (pe_reset) begin
      pe_widx = 0; pe_pix = 0; pe_emitted = 0; pe_extra = 1'b0; pe_pass++;
    end else begin
      if (pe_extra) begin
        pe_conv_out <= 1'b1;
        pe_dataout  <= 16'($urandom);
        pe_extra = 1'b0;
      end
      if (pe_weight_enable && pe_widx < 25) begin
        pe_w[pe_widx] = pe_weight;
        pe_widx++;
      end
      if (pe_enable && pe_pix < 144) begin
        pe_img[pe_pix] = pe_datain;
        r = pe_pix / 12;
        c = pe_pix % 12;
        if (r >= 4 && c >= 4 && pe_emitted < ((pe_pass == drop_pass) ? 60 : 64)) begin
          acc = 0;
          for (int kr = 0; kr < 5; kr++)
            for (int kc = 0; kc < 5; kc++)
              acc += int'(pe_w[kr*5+kc]) * int'(pe_img[(r-4+kr)*12 + (c-4+kc)]);
          pe_conv_out <= 1'b1;
          pe_dataout  <= 16'(acc);
          pe_emitted++;
          if (pe_emitted == 64 && inject) pe_extra = 1'b1;
        end
        pe_pix++;
      end
    end
  end

  logic [15:0] exp_d [$];
  logic [3:0]  exp_c [$];
  logic [5:0]  exp_i [$];

  // Whole-layer expectation straight from the ROM layout and convolution definition.
  task automatic build_model();
    logic [15:0] ps [64];
    logic [15:0] s;
    int acc, b, n;
    exp_d.delete(); exp_c.delete(); exp_i.delete();
    for (int oc = 0; oc < OUT_CH; oc++) begin
      b = oc * (IN_CH*25 + 1);
      for (int ic = 0; ic < IN_CH; ic++) begin
        n = (oc*IN_CH + ic == drop_pass) ? 60 : 64;
        for (int i = 0; i < n; i++) begin
          acc = 0;
          for (int kr = 0; kr < 5; kr++)
            for (int kc = 0; kc < 5; kc++)
              acc += int'(wrom[b + ic*25 + kr*5 + kc]) * int'(from[ic*144 + (i/8+kr)*12 + (i%8+kc)]);
          ps[i] = ((ic == 0) ? 16'd0 : ps[i]) + 16'(acc);
        end
      end
      for (int i = 0; i < 64; i++) begin
        s = ps[i] + wrom[b + IN_CH*25];
`ifdef LAYER2_SCHED_RELU_EN
        if (s[15]) s = 16'd0;
`endif
        exp_d.push_back(s);
        exp_c.push_back(4'(oc));
        exp_i.push_back(6'(i));
      end
    end
  endtask

  int total, bad;
  int n_out, done_cnt, mon_pass;
  int en_cnt [128];
  int wen_cnt [128];
  int err_at [128];
  logic signed [15:0] first_out [16];

  always @(negedge clk) begin : compare
    logic [15:0] ed;
    logic [3:0]  ec;
    logic [5:0]  ei;
    if (pe_enable || pe_weight_enable) begin
      total++;
      if (pe_enable && pe_weight_enable) begin
        bad++;
        $display("FAIL pe_excl got enable=1 weight_enable=1 want at most one");
      end
    end
    if (pe_reset) begin
      mon_pass++;
      if (mon_pass >= 0 && mon_pass < 128) err_at[mon_pass] = int'(err);
    end else if (mon_pass >= 0 && mon_pass < 128) begin
      if (pe_enable) en_cnt[mon_pass]++;
      if (pe_weight_enable) wen_cnt[mon_pass]++;
    end
    if (done) done_cnt++;
    if (out_valid) begin
      n_out++;
      if (out_idx == 6'd0) first_out[out_ch] = out_data;
      total++;
      if (exp_d.size() == 0) begin
        bad++;
        $display("FAIL out_extra got ch=%0d idx=%0d data=%0d want no output", out_ch, out_idx, $signed(out_data));
      end else begin
        ed = exp_d.pop_front(); ec = exp_c.pop_front(); ei = exp_i.pop_front();
        if (out_data !== ed || out_ch !== ec || out_idx !== ei) begin
          bad++;
          $display("FAIL out_sample got ch=%0d idx=%0d data=%0d want ch=%0d idx=%0d data=%0d",
                   out_ch, out_idx, $signed(out_data), ec, ei, $signed(ed));
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 4096; i++) wrom[i] = 16'(int'($urandom_range(15)) - 8);
    for (int i = 0; i < 1024; i++) from[i] = 16'(int'($urandom_range(255)) - 128);
    for (int oc = 0; oc < OUT_CH; oc++) wrom[oc*(IN_CH*25+1) + IN_CH*25] = 16'($urandom);
  endtask

  task automatic fill_const();
    for (int i = 0; i < 4096; i++) wrom[i] = 16'sd1;
    for (int i = 0; i < 1024; i++) from[i] = 16'sd1;
    for (int oc = 0; oc < OUT_CH; oc++)
      wrom[oc*(IN_CH*25+1) + IN_CH*25] = (oc % 2 == 0) ? -16'sd5 : -16'sd200;
  endtask

  task automatic prep_layer();
    build_model();
    n_out = 0; mon_pass = -1; pe_pass = -1;
    for (int i = 0; i < 128; i++) begin en_cnt[i] = 0; wen_cnt[i] = 0; err_at[i] = -1; end
  endtask

  task automatic run_layer(input bit extra_starts);
    int cyc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    cyc = 0;
    while (cyc < 30000) begin
      @(negedge clk);
      cyc++;
      start = extra_starts && (cyc % 3000 == 7);
      if (done) break;
    end
    start = 1'b0;
    chk("done_seen", int'(done), 1);
    chk("busy_at_done", int'(busy), 1);
    chk("queue_empty", exp_d.size(), 0);
    chk("n_out", n_out, 1024);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
  endtask

  initial begin : main
    int fmc, cyc, d0;
    total = 0; bad = 0; done_cnt = 0; n_out = 0;
    reset = 1'b1; start = 1'b0; drop_pass = -1; inject = 1'b0; pe_pass = -1; mon_pass = -1;
    repeat (3) @(negedge clk);
    chk("rst_flags", int'({busy, done, err, wt_rd_en, fm_rd_en, pe_reset, pe_enable, pe_weight_enable, out_valid}), 0);
    chk("rst_buses", int'(|{wt_addr, fm_addr, pe_datain, pe_weight, out_data, out_ch, out_idx}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // Pass 7 (oc1, ic1) gets only 60 results: drain timeout, err sticks, layer still completes.
    fill_rand();
    drop_pass = 7;
    prep_layer();
    run_layer(1'b0);
    chk("err_set", int'(err), 1);
    chk("err_before_drop", err_at[7], 0);
    chk("err_after_drop", err_at[8], 1);
    chk("drop_pass_enables", en_cnt[7], 144 + 16);
    chk("normal_pass_enables", en_cnt[0], 145);
    chk("wen_first_pass", wen_cnt[0], 25);
    chk("wen_last_pass", wen_cnt[95], 25);
    chk("pass_count", mon_pass, 95);

    // Accepted start clears err; reset at read 100 of the first stream aborts silently.
    drop_pass = -1;
    exp_d.delete(); exp_c.delete(); exp_i.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("err_cleared", int'(err), 0);
    fmc = 0; cyc = 0;
    while (fmc < 100 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (fm_rd_en) fmc++;
    end
    chk("stream_reached", fmc, 100);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_strobes", int'({fm_rd_en, wt_rd_en, pe_enable, pe_weight_enable, pe_reset, out_valid, done}), 0);
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", int'(busy), 0);

    // Clean random layer with stray starts and a 65th result per pass.
    fill_rand();
    inject = 1'b1;
    prep_layer();
    run_layer(1'b1);
    chk("no_err_clean", int'(err), 0);
    inject = 1'b0;

    // Constant layer: 6*25-5 = 145 on even maps, 150-200 = -50 on odd maps.
    fill_const();
    prep_layer();
    chk("model_pin_even", int'($signed(exp_d[0])), 145);
    chk("model_pin_odd", int'($signed(exp_d[64])), EXP_NEG);
    run_layer(1'b0);
    chk("lit_oc0", int'(first_out[0]), 145);
    chk("lit_oc1", int'(first_out[1]), EXP_NEG);
    chk("lit_oc15", int'(first_out[15]), EXP_NEG);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
